// File: rtl/led_pkg.sv
// Shared types, mode encodings and pattern helpers for the led_ctrl sequencer.
// Optional debounce is selected with LED_CTRL_DEBOUNCE_EN (see led_ctrl.sv).
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_ROL    = 2'b00;
   localparam mode_t MODE_ROR    = 2'b01;
   localparam mode_t MODE_BOUNCE = 2'b10;
   localparam mode_t MODE_FILL   = 2'b11;

   localparam logic [15:0] START_ROL    = 16'h0001;
   localparam logic [15:0] START_ROR    = 16'h8000;
   localparam logic [15:0] START_BOUNCE = 16'h0001;
   localparam logic [15:0] START_FILL   = 16'h0001;
   localparam logic [15:0] FILL_FULL    = 16'hFFFF;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   typedef struct packed {
      logic [15:0] pattern;
      dir_t        dir;
   } pat_t;

   localparam pat_t PAT_CLEAR = '{pattern: 16'h0000, dir: DIR_LEFT};

   function automatic pat_t start_of(input mode_t m);
      pat_t p;
      p.dir = DIR_LEFT;
      unique case (m)
         MODE_ROL:    p.pattern = START_ROL;
         MODE_ROR:    p.pattern = START_ROR;
         MODE_BOUNCE: p.pattern = START_BOUNCE;
         default:     p.pattern = START_FILL;
      endcase
      return p;
   endfunction

   // Bounce flips direction on the step that lands on an end bit, so the
   // following step heads back inward.
   function automatic pat_t advance(input pat_t cur, input mode_t m);
      pat_t nxt;
      nxt = cur;
      unique case (m)
         MODE_ROL: nxt.pattern = {cur.pattern[14:0], cur.pattern[15]};
         MODE_ROR: nxt.pattern = {cur.pattern[0], cur.pattern[15:1]};
         MODE_BOUNCE: begin
            if (cur.dir == DIR_LEFT) begin
               nxt.pattern = {cur.pattern[14:0], 1'b0};
               if (nxt.pattern[15]) nxt.dir = DIR_RIGHT;
            end else begin
               nxt.pattern = {1'b0, cur.pattern[15:1]};
               if (nxt.pattern[0]) nxt.dir = DIR_LEFT;
            end
         end
         default: nxt.pattern = (cur.pattern == FILL_FULL) ? 16'h0000
                                                          : {cur.pattern[14:0], 1'b1};
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/led_debounce.sv
// Enable debouncer: q follows d only after d has disagreed with q for DB_CYCLES
// consecutive cycles. Instantiated by led_ctrl when LED_CTRL_DEBOUNCE_EN is defined.
module led_debounce #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   localparam int unsigned    CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         q   <= 1'b0;
         cnt <= '0;
      end else if (d == q) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         q   <= d;
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_ctrl.sv
// 16-LED pattern sequencer with IDLE/RUN/PAUSE control and a step prescaler.
// Define LED_CTRL_DEBOUNCE_EN to filter the switch enable through led_debounce.
module led_ctrl
   import led_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 5_000_000,
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  sw,
   input  logic [1:0]  mode,
   output logic [15:0] ledr,
   output logic        busy,
   output logic        step
);

   localparam int unsigned        PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);

   logic [1:0]    sw_meta;
   logic [1:0]    sw_sync;
   logic          en_s;
   logic          en;
   state_t        state;
   mode_t         lmode;
   pat_t          cur;
   logic [PW-1:0] presc;

   // NOTE: every clocked register uses <= so all flops sample pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sw_meta <= 2'b00;
         sw_sync <= 2'b00;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
      end
   end

   assign en_s = sw_sync[0] ^ sw_sync[1];

`ifdef LED_CTRL_DEBOUNCE_EN
   led_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk (clk),
      .rst (rst),
      .d   (en_s),
      .q   (en)
   );
`else
   // DB_CYCLES has no effect when the debouncer is compiled out.
   logic unused_db;
   assign unused_db = ^DB_CYCLES;
   assign en        = en_s;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         lmode <= MODE_ROL;
         cur   <= PAT_CLEAR;
         presc <= '0;
         busy  <= 1'b0;
         step  <= 1'b0;
      end else begin
         step <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (en) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  lmode <= mode;
                  cur   <= start_of(mode);
                  presc <= '0;
               end
            end
            ST_RUN: begin
               // Dropping enable wins over a coincident step.
               if (!en) begin
                  state <= ST_PAUSE;
                  busy  <= 1'b0;
               end else if (presc == PRESC_LAST) begin
                  presc <= '0;
                  step  <= 1'b1;
                  if (mode != lmode) begin
                     lmode <= mode;
                     cur   <= start_of(mode);
                  end else begin
                     cur   <= advance(cur, lmode);
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (mode != lmode) begin
                  state <= ST_IDLE;
                  cur   <= PAT_CLEAR;
               end else if (en) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cur   <= PAT_CLEAR;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ledr = cur.pattern;

endmodule
